// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// CPU-side initiator for the ram512x8 MOV/MOC four-phase handshake. Accepts a
// single load/store request from the datapath, checks opcode and alignment,
// drives the RAM bus, waits for MOC (through a synchronizer) and reports
// completion. Doubleword accesses (LDC1/SDC1) run as two 32-bit beats at the
// same address; the RAM advances to the second word on its own.
//
// Optional feature: define MEMCTL_TIMEOUT_EN to add a per-beat watchdog that
// aborts a stalled transfer after TIMEOUT_CYCLES cycles in REQ/RELEASE.
//
// Ports
//   Clk, Reset_n   clock (rising edge), asynchronous active-low reset
//   Start          request strobe, only looked at in IDLE
//   OpCodeIn       MIPS opcode of the request
//   AddrIn         byte address of the request
//   StoreData      store payload ([63:32] beat 0 of SDC1, [31:0] otherwise)
//   Busy           high from request acceptance until Done
//   Done           one-cycle completion pulse
//   Error          one-cycle pulse with Done on a rejected/aborted request
//   LoadData       load result (beat 0 -> [63:32], beat 1 / single -> [31:0])
//   MOV            memory operation valid
//   ReadWrite      1 = read, 0 = write
//   Address        RAM byte address
//   DataIn         RAM write data
//   OpCode         opcode forwarded to the RAM (it does sign/zero extension)
//   DataOut        RAM read data
//   MOC            memory operation complete (asynchronous to Clk)
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int ADDR_W         = 9,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [5:0]        OpCodeIn,
    input  logic [ADDR_W-1:0] AddrIn,
    input  logic [63:0]       StoreData,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [63:0]       LoadData,
    output logic              MOV,
    output logic              ReadWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [31:0]       DataIn,
    output logic [5:0]        OpCode,
    input  logic [31:0]       DataOut,
    input  logic              MOC
);

    typedef enum logic [2:0] {IDLE, CHECK, SETUP, REQ, RELEASE, FIN} state_e;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DBL} size_e;

    typedef struct packed {
        logic  valid;
        logic  store;
        size_e size;
    } decode_t;

    function automatic decode_t decode_op(input logic [5:0] op);
        decode_t d;
        d.valid = 1'b1;
        d.store = 1'b0;
        d.size  = SZ_BYTE;
        case (op)
            6'b100000, 6'b100100: d.size = SZ_BYTE;                 // LB, LBU
            6'b100001, 6'b100101: d.size = SZ_HALF;                 // LH, LHU
            6'b100011:            d.size = SZ_WORD;                 // LW
            6'b110101:            d.size = SZ_DBL;                  // LDC1
            6'b101000: begin d.store = 1'b1; d.size = SZ_BYTE; end  // SB
            6'b101001: begin d.store = 1'b1; d.size = SZ_HALF; end  // SH
            6'b101011: begin d.store = 1'b1; d.size = SZ_WORD; end  // SW
            6'b111101: begin d.store = 1'b1; d.size = SZ_DBL;  end  // SDC1
            default:   d.valid = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic misaligned(input size_e size, input logic [2:0] lsb);
        case (size)
            SZ_HALF: return lsb[0];
            SZ_WORD: return |lsb[1:0];
            SZ_DBL:  return |lsb;
            default: return 1'b0;
        endcase
    endfunction

    state_e            state, state_next;
    logic [5:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       sd_q;
    logic              err_q;
    logic              beat_q;
    decode_t           dec;

    logic accept, load_bus, capture, set_err;
    logic moc_s;
    logic timeout_hit;

    assign dec = decode_op(op_q);

    // ------------------------------------------------------------------
    // MOC synchronizer
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] moc_sync;

    generate
        if (SYNC_STAGES == 1) begin : g_sync_single
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) moc_sync <= '0;
                else          moc_sync <= MOC;
            end
        end else begin : g_sync_chain
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) moc_sync <= '0;
                else          moc_sync <= {moc_sync[SYNC_STAGES-2:0], MOC};
            end
        end
    endgenerate

    assign moc_s = moc_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Optional per-beat watchdog
    // ------------------------------------------------------------------
`ifdef MEMCTL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;
    logic             waiting;

    assign waiting     = (state == REQ) || (state == RELEASE);
    // Fires on the TIMEOUT_CYCLES-th waiting cycle of the current beat.
    assign timeout_hit = waiting && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)                     to_cnt <= '0;
        else if (state == SETUP)          to_cnt <= '0;
        else if (waiting && !timeout_hit) to_cnt <= to_cnt + 1'b1;
    end
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!Reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_next = state;
        accept     = 1'b0;
        load_bus   = 1'b0;
        capture    = 1'b0;
        set_err    = 1'b0;

        case (state)
            IDLE: begin
                if (Start) begin
                    accept     = 1'b1;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (!dec.valid || misaligned(dec.size, addr_q[2:0])) begin
                    set_err    = 1'b1;
                    state_next = FIN;
                end else begin
                    load_bus   = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: state_next = REQ;
            REQ: begin
                if (timeout_hit) begin
                    set_err    = 1'b1;
                    state_next = FIN;
                end else if (moc_s) begin
                    capture    = 1'b1;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (timeout_hit) begin
                    set_err    = 1'b1;
                    state_next = FIN;
                end else if (!moc_s) begin
                    if (dec.size == SZ_DBL && !beat_q) begin
                        load_bus   = 1'b1;
                        state_next = SETUP;
                    end else begin
                        state_next = FIN;
                    end
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, bus drivers and status outputs
    // ------------------------------------------------------------------
    logic        next_beat;
    logic [31:0] beat_wdata;

    // Bus is loaded when entering SETUP; from RELEASE that is the second beat.
    assign next_beat  = (state == RELEASE);
    assign beat_wdata = (dec.size == SZ_DBL && !next_beat) ? sd_q[63:32] : sd_q[31:0];

    always_ff @(posedge Clk or negedge Reset_n) begin
        // NOTE: all control and bus registers are reset so the RAM sees an
        // idle, read-direction bus and the datapath sees no stale result.
        if (!Reset_n) begin
            op_q      <= '0;
            addr_q    <= '0;
            sd_q      <= '0;
            err_q     <= 1'b0;
            beat_q    <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Error     <= 1'b0;
            LoadData  <= '0;
            MOV       <= 1'b0;
            ReadWrite <= 1'b1;
            Address   <= '0;
            DataIn    <= '0;
            OpCode    <= '0;
        end else begin
            // MOV is high exactly while the FSM sits in REQ.
            MOV   <= (state_next == REQ);
            Done  <= (state_next == FIN);
            Error <= (state_next == FIN) && (err_q || set_err);

            if (accept) begin
                op_q   <= OpCodeIn;
                addr_q <= AddrIn;
                sd_q   <= StoreData;
                err_q  <= 1'b0;
                Busy   <= 1'b1;
            end

            if (set_err)      err_q <= 1'b1;
            if (state == FIN) Busy  <= 1'b0;

            if (load_bus) begin
                Address   <= addr_q;
                OpCode    <= op_q;
                ReadWrite <= ~dec.store;
                DataIn    <= beat_wdata;
                beat_q    <= next_beat;
            end

            if (capture && !dec.store) begin
                if (dec.size != SZ_DBL)  LoadData          <= {32'h0, DataOut};
                else if (!beat_q)        LoadData[63:32]   <= DataOut;
                else                     LoadData[31:0]    <= DataOut;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed bench for mem_access_ctrl. A behavioural ram512x8 responder
// (big-endian byte array, sign/zero extension by opcode, internal doubleword
// sequencing) answers the MOV/MOC handshake on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic [5:0]  OpCodeIn;
    logic [8:0]  AddrIn;
    logic [63:0] StoreData;
    logic        Busy, Done, Error;
    logic [63:0] LoadData;
    logic        MOV, ReadWrite;
    logic [8:0]  Address;
    logic [31:0] DataIn;
    logic [5:0]  OpCode;
    logic [31:0] DataOut;
    logic        MOC;

    mem_access_ctrl dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .OpCodeIn  (OpCodeIn),
        .AddrIn    (AddrIn),
        .StoreData (StoreData),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error),
        .LoadData  (LoadData),
        .MOV       (MOV),
        .ReadWrite (ReadWrite),
        .Address   (Address),
        .DataIn    (DataIn),
        .OpCode    (OpCode),
        .DataOut   (DataOut),
        .MOC       (MOC)
    );

    always #5 Clk = ~Clk;

    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_LH   = 6'b100001;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_LBU  = 6'b100100;
    localparam logic [5:0] OP_LDC1 = 6'b110101;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_SDC1 = 6'b111101;

    int total = 0;
    int bad   = 0;

    // RAM model and MOV pulse recorder
    logic [7:0]  mem [0:511];
    logic        moc_stuck = 1'b0;
    logic        mov_prev  = 1'b0;
    int          ram_beat  = 0;
    int          neg_cnt   = 0;
    int          pulse_cnt = 0;
    int          pulse_neg [4];
    logic [8:0]  pulse_addr [4];
    logic [31:0] pulse_data [4];
    logic        pulse_rw [4];
    logic [5:0]  pulse_op [4];
    int          orphan_err = 0;

    // Results of the last do_req
    int          base;
    int          r_lat;
    logic        r_done;
    logic        r_err;
    logic        r_busy1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input int a);
        return {mem[a & 511], mem[(a + 1) & 511], mem[(a + 2) & 511], mem[(a + 3) & 511]};
    endfunction

    initial begin
        DataOut = '0;
        MOC     = 1'b0;
        forever begin
            @(negedge Clk);
            neg_cnt++;
            if (Error && !Done) orphan_err++;
            if (MOV && !mov_prev && pulse_cnt < 4) begin
                pulse_neg[pulse_cnt]  = neg_cnt;
                pulse_addr[pulse_cnt] = Address;
                pulse_data[pulse_cnt] = DataIn;
                pulse_rw[pulse_cnt]   = ReadWrite;
                pulse_op[pulse_cnt]   = OpCode;
                pulse_cnt++;
            end
            mov_prev = MOV;
            if (!Reset_n) begin
                MOC      = 1'b0;
                ram_beat = 0;
            end else if (MOV && !MOC && !moc_stuck) begin
                int a;
                a = int'(Address) + 4 * ram_beat;
                if (ReadWrite) begin
                    case (OpCode)
                        6'b100000: DataOut = {{24{mem[a & 511][7]}}, mem[a & 511]};
                        6'b100100: DataOut = {24'h0, mem[a & 511]};
                        6'b100001: DataOut = {{16{mem[a & 511][7]}}, mem[a & 511], mem[(a + 1) & 511]};
                        6'b100101: DataOut = {16'h0, mem[a & 511], mem[(a + 1) & 511]};
                        default:   DataOut = rd_word(a);
                    endcase
                end else begin
                    case (OpCode)
                        6'b101000: mem[a & 511] = DataIn[7:0];
                        6'b101001: begin
                            mem[a & 511]       = DataIn[15:8];
                            mem[(a + 1) & 511] = DataIn[7:0];
                        end
                        default: begin
                            mem[a & 511]       = DataIn[31:24];
                            mem[(a + 1) & 511] = DataIn[23:16];
                            mem[(a + 2) & 511] = DataIn[15:8];
                            mem[(a + 3) & 511] = DataIn[7:0];
                        end
                    endcase
                end
                if (OpCode == OP_LDC1 || OpCode == OP_SDC1) ram_beat = (ram_beat == 0) ? 1 : 0;
                MOC = 1'b1;
            end else if (!MOV && MOC) begin
                MOC = 1'b0;
            end
        end
    end

    // Issues one request and waits (bounded) for Done. Inputs are scrambled
    // after acceptance so the DUT must use its latched copy.
    task automatic do_req(input logic [5:0] op, input logic [8:0] addr, input logic [63:0] sd);
        int guard;
        guard = 0;
        @(negedge Clk);
        while (Busy !== 1'b0 && guard < 50) begin
            @(negedge Clk);
            guard++;
        end
        pulse_cnt = 0;
        OpCodeIn  = op;
        AddrIn    = addr;
        StoreData = sd;
        Start     = 1'b1;
        @(posedge Clk);
        #1;
        Start     = 1'b0;
        base      = neg_cnt;
        OpCodeIn  = 6'b111111;
        AddrIn    = 9'h1FF;
        StoreData = '1;
        r_done    = 1'b0;
        r_err     = 1'b0;
        r_lat     = 0;
        r_busy1   = 1'b0;
        for (int n = 1; n <= 60 && !r_done; n++) begin
            @(negedge Clk);
            if (n == 1) r_busy1 = Busy;
            if (Done === 1'b1) begin
                r_done = 1'b1;
                r_lat  = n;
                r_err  = Error;
            end
        end
        check("done_seen", 64'(r_done), 64'd1);
    endtask

    initial begin
        int done_any;
        int guard;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[1]    = 8'hA6;
        Reset_n   = 1'b0;
        Start     = 1'b0;
        OpCodeIn  = '0;
        AddrIn    = '0;
        StoreData = '0;
        repeat (3) @(negedge Clk);

        // Reset state
        check("rst_mov",   64'(MOV),       64'd0);
        check("rst_rw",    64'(ReadWrite), 64'd1);
        check("rst_addr",  64'(Address),   64'd0);
        check("rst_din",   64'(DataIn),    64'd0);
        check("rst_op",    64'(OpCode),    64'd0);
        check("rst_ld",    LoadData,       64'd0);
        check("rst_busy",  64'(Busy),      64'd0);
        check("rst_done",  64'(Done),      64'd0);
        check("rst_error", 64'(Error),     64'd0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // LBU 0x001: CHECK, SETUP, REQ(3), RELEASE(3) -> Done on 9th cycle
        do_req(OP_LBU, 9'h001, 64'h0);
        check("lbu_busy",    64'(r_busy1),       64'd1);
        check("lbu_movrise", 64'(pulse_neg[0] - base), 64'd3);
        check("lbu_pulses",  64'(pulse_cnt),     64'd1);
        check("lbu_op",      64'(pulse_op[0]),   64'(OP_LBU));
        check("lbu_rw",      64'(pulse_rw[0]),   64'd1);
        check("lbu_lat",     64'(r_lat),         64'd9);
        check("lbu_err",     64'(r_err),         64'd0);
        check("lbu_data",    LoadData,           64'h00000000_000000A6);

        // LB 0x001: sign extension comes from the RAM
        do_req(OP_LB, 9'h001, 64'h0);
        check("lb_op",   64'(pulse_op[0]), 64'(OP_LB));
        check("lb_data", LoadData,         64'h00000000_FFFFFFA6);

        // SW 0x018
        do_req(OP_SW, 9'h018, 64'h12345678_EEEEEEEE);
        check("sw_pulses", 64'(pulse_cnt),     64'd1);
        check("sw_rw",     64'(pulse_rw[0]),   64'd0);
        check("sw_din",    64'(pulse_data[0]), 64'hEEEEEEEE);
        check("sw_addr",   64'(pulse_addr[0]), 64'h018);
        check("sw_err",    64'(r_err),         64'd0);
        check("sw_ld_hold", LoadData,          64'h00000000_FFFFFFA6);

        // LW 0x018 reads back the store (back-to-back start right after FIN)
        do_req(OP_LW, 9'h018, 64'h0);
        check("lw_data", LoadData, 64'h00000000_EEEEEEEE);

        // SDC1 0x020: two beats, same address, high word first
        do_req(OP_SDC1, 9'h020, 64'hCCCCCCCC_88888888);
        check("sdc1_pulses", 64'(pulse_cnt),     64'd2);
        check("sdc1_addr0",  64'(pulse_addr[0]), 64'h020);
        check("sdc1_addr1",  64'(pulse_addr[1]), 64'h020);
        check("sdc1_din0",   64'(pulse_data[0]), 64'hCCCCCCCC);
        check("sdc1_din1",   64'(pulse_data[1]), 64'h88888888);
        check("sdc1_lat",    64'(r_lat),         64'd16);

        // LDC1 0x020
        do_req(OP_LDC1, 9'h020, 64'h0);
        check("ldc1_pulses", 64'(pulse_cnt), 64'd2);
        check("ldc1_data",   LoadData,       64'hCCCCCCCC_88888888);
        check("ldc1_err",    64'(r_err),     64'd0);

        // Misaligned and unsupported requests: Done+Error after 2 cycles, no MOV
        do_req(OP_LH, 9'h003, 64'h0);
        check("lh_mis_err",    64'(r_err),     64'd1);
        check("lh_mis_lat",    64'(r_lat),     64'd2);
        check("lh_mis_pulses", 64'(pulse_cnt), 64'd0);
        do_req(OP_LW, 9'h006, 64'h0);
        check("lw_mis_err",    64'(r_err),     64'd1);
        check("lw_mis_lat",    64'(r_lat),     64'd2);
        check("lw_mis_pulses", 64'(pulse_cnt), 64'd0);
        check("lw_mis_ld",     LoadData,       64'hCCCCCCCC_88888888);
        do_req(6'b000000, 9'h000, 64'h0);
        check("badop_err",    64'(r_err),     64'd1);
        check("badop_pulses", 64'(pulse_cnt), 64'd0);

        // Reset while in REQ with MOC held low
        moc_stuck = 1'b1;
        @(negedge Clk);
        OpCodeIn = OP_LW;
        AddrIn   = 9'h018;
        Start    = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        guard = 0;
        while (MOV !== 1'b1 && guard < 20) begin
            @(negedge Clk);
            guard++;
        end
        check("stall_mov_up", 64'(MOV), 64'd1);
        @(posedge Clk);
        #3;
        Reset_n = 1'b0;
        #1;
        check("arst_mov",  64'(MOV),  64'd0);
        check("arst_busy", 64'(Busy), 64'd0);
        check("arst_done", 64'(Done), 64'd0);
        check("arst_ld",   LoadData,  64'd0);
        done_any = 0;
        repeat (2) begin
            @(negedge Clk);
            if (Done) done_any++;
        end
        Reset_n   = 1'b1;
        moc_stuck = 1'b0;
        repeat (10) begin
            @(negedge Clk);
            if (Done) done_any++;
        end
        check("arst_no_done", 64'(done_any), 64'd0);

        // Recovery after reset
        do_req(OP_LBU, 9'h001, 64'h0);
        check("post_rst_data", LoadData,    64'h00000000_000000A6);
        check("post_rst_err",  64'(r_err),  64'd0);
        check("error_only_with_done", 64'(orphan_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- CPU-side initiator for the ram512x8 MOV/MOC handshake.
- Accepts one load/store request from the datapath and drives ReadWrite, Address, DataIn, OpCode and MOV toward the RAM.
- Waits for MOC, captures DataOut, and reports completion to the datapath.
- Doubleword accesses (LDC1/SDC1) run as two 32-bit beats; misaligned or unsupported requests are rejected without touching the RAM.

Parameters:
- ADDR_W, 9, RAM address width.
- SYNC_STAGES, 2, flops in the MOC synchronizer (1 or 2).
- TIMEOUT_CYCLES, 16, watchdog limit per beat (used only with MEMCTL_TIMEOUT_EN).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Start  in  1  request strobe, sampled only in IDLE.
- OpCodeIn  in  6  MIPS opcode of the request.
- AddrIn  in  ADDR_W  byte address of the request.
- StoreData  in  64  store payload; [63:32] goes in beat 0, [31:0] in beat 1; SB/SH/SW use [31:0].
- Busy  out  1  high from Start acceptance until Done.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  one-cycle pulse, coincident with Done, on a rejected or aborted request.
- LoadData  out  64  load result; beat 0 lands in [63:32], beat 1 in [31:0]; single-beat loads land in [31:0] with [63:32]=0.
- MOV  out  1  memory operation valid.
- ReadWrite  out  1  1=read, 0=write.
- Address  out  ADDR_W  RAM address.
- DataIn  out  32  RAM write data.
- OpCode  out  6  opcode passed to RAM (the RAM performs sign/zero extension).
- DataOut  in  32  RAM read data.
- MOC  in  1  memory operation complete.

Behaviour:
- Reset values: MOV=0, ReadWrite=1, Address=0, DataIn=0, OpCode=0, LoadData=0, Busy=0, Done=0, Error=0; state=IDLE; MOC synchronizer cleared.
- Reset asserted mid-transfer aborts immediately; no Done is generated.
- Supported loads: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, LDC1 110101.
- Supported stores: SB 101000, SH 101001, SW 101011, SDC1 111101.
- Every other opcode is rejected.
- Alignment rules:
  - halfword: AddrIn[0]=0
  - word: AddrIn[1:0]=0
  - doubleword: AddrIn[2:0]=0
- States: IDLE, CHECK, SETUP, REQ, RELEASE, FIN.
- IDLE: if Start=1, latch OpCodeIn, AddrIn and StoreData; set Busy=1; go to CHECK. Start in any other state is ignored.
- CHECK (1 cycle):
  - Invalid opcode or misaligned address -> FIN with error flag set; MOV is never raised.
  - Otherwise: beat=0, go to SETUP.
- SETUP (1 cycle):
  - Drive Address, OpCode, ReadWrite and DataIn (beat 0: SD[63:32] for SDC1, else SD[31:0]; beat 1: SD[31:0]).
  - MOV stays 0, giving one cycle of bus setup before MOV rises.
- REQ:
  - MOV=1; hold until synchronized MOC=1.
  - On that edge, for reads capture DataOut into the beat's LoadData slice.
  - Then MOV=0; go to RELEASE.
- RELEASE:
  - MOV=0; wait for synchronized MOC=0 (four-phase handshake).
  - If doubleword and beat=0: beat=1, go to SETUP. Address is unchanged; the RAM sequences the second word internally.
  - Otherwise go to FIN.
- FIN (1 cycle): Done=1, Error=error flag, Busy=0 on the next edge, return to IDLE.
- A back-to-back Start is accepted in the IDLE cycle that follows FIN.
- Bus outputs hold their last values in IDLE. LoadData holds until the next accepted load; stores do not alter it.
- Latency: single beat = 4 cycles + MOC rise + MOC fall synchronizer delays. Doubleword = 2 × (SETUP+REQ+RELEASE) + CHECK + FIN.
- MOC already high on entering REQ: completion is taken after sync delay. The response of the previous access must have released, which RELEASE guarantees.

Optional Feature:
- Macro: MEMCTL_TIMEOUT_EN.
- Defined:
  - A per-beat counter runs in REQ and RELEASE and clears in SETUP.
  - On reaching TIMEOUT_CYCLES the transfer aborts: MOV=0, go to FIN with Error=1. A remaining doubleword beat is skipped.
- Undefined: no counter is instantiated; the FSM waits indefinitely for MOC.

Test Plan:
- LBU, AddrIn=0x001, RAM Mem[1]=8'hA6 -> MOV rises 1 cycle after SETUP; LoadData=64'h00000000_000000A6; Done pulse; Error=0.
- LB, AddrIn=0x001, Mem[1]=8'hA6 -> OpCode=100000 on bus; LoadData[31:0]=32'hFFFFFFA6 as returned by RAM.
- SW, AddrIn=0x018, StoreData[31:0]=32'hEEEEEEEE -> ReadWrite=0, DataIn=32'hEEEEEEEE during MOV; exactly one MOV pulse. A following LW at 0x018 returns 32'hEEEEEEEE.
- SDC1, AddrIn=0x020, StoreData=64'hCCCCCCCC_88888888 -> two MOV pulses, Address=0x020 both times; DataIn=CCCCCCCC then 88888888. A following LDC1 returns the same 64-bit value.
- LH at 0x003 and LW at 0x006 -> Done+Error pulse 2 cycles after Start; MOV never asserted; LoadData unchanged.
- Reset_n low while in REQ -> MOV=0 and Busy=0 asynchronously, no Done. With MEMCTL_TIMEOUT_EN and MOC stuck at 0 -> Error+Done after 16 REQ cycles.
